// File: rtl/sm_vcu_reg_scheduler_if.sv
// Bundle of the CPU-select, peripheral read-port and mirror signals of sm_vcu_reg_scheduler.
// CPU select uses valid/ready: the request is taken on a rising edge where cpu_sel_valid and cpu_sel_ready are both 1.
// The peripheral port is req/ack: per_req and per_idx are held until a one-cycle per_ack or the scheduler's timeout.
interface sm_vcu_reg_scheduler_if #(
    parameter int IDX_W = 2
) ();
    logic             poll_en;
    logic             cpu_sel_valid;
    logic [IDX_W-1:0] cpu_sel_idx;
    logic             cpu_sel_ready;
    logic             per_req;
    logic [IDX_W-1:0] per_idx;
    logic             per_ack;
    logic [31:0]      per_rdata;
    logic [31:0]      vcu_reg_rdata;
    logic [IDX_W-1:0] vcu_cur_idx;
    logic             vcu_upd;
    logic             vcu_timeout;
    logic             vcu_timeout_clr;

    modport master (
        input  poll_en, cpu_sel_valid, cpu_sel_idx, per_ack, per_rdata, vcu_timeout_clr,
        output cpu_sel_ready, per_req, per_idx, vcu_reg_rdata, vcu_cur_idx, vcu_upd, vcu_timeout
    );

    modport slave (
        output poll_en, cpu_sel_valid, cpu_sel_idx, per_ack, per_rdata, vcu_timeout_clr,
        input  cpu_sel_ready, per_req, per_idx, vcu_reg_rdata, vcu_cur_idx, vcu_upd, vcu_timeout
    );
endinterface

// File: rtl/sm_vcu_reg_scheduler.sv
// Sequences VCU status-register reads over one req/ack port and mirrors the latest result for x30.
// Background round-robin polling, one-shot CPU select that pre-empts it, and a per-read timeout.
module sm_vcu_reg_scheduler #(
    parameter int NUM_SRC  = 4,
    parameter int IDX_W    = 2,
    parameter int POLL_GAP = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sm_vcu_reg_scheduler_if.master bus,
    output logic [1:0]             dbg_state
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_UPD  = 2'd2;

    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_INIT  = GAP_W'(POLL_GAP);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] RR_LAST   = IDX_W'(NUM_SRC - 1);
    localparam logic [31:0]      NUM_SRC_W = 32'(NUM_SRC);
    localparam logic [31:0]      ERR_DATA  = 32'hDEAD_BEEF;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] rr_next;
    logic             is_poll;
    logic [GAP_W-1:0] gap;
    logic [TO_W-1:0]  tcnt;
    logic             per_req_q;
    logic [31:0]      mirror;
    logic [IDX_W-1:0] cur_idx;
    logic             upd_q;
    logic             timeout_q;
    logic [31:0]      sel_idx_ext;
    logic             sel_err;

    // Out-of-range CPU indices never reach the peripheral; they complete as an error read.
    assign sel_idx_ext = 32'(bus.cpu_sel_idx);
    assign sel_err     = (sel_idx_ext >= NUM_SRC_W);
    assign rr_next     = (rr == RR_LAST) ? '0 : rr + IDX_W'(1);

    assign bus.cpu_sel_ready = (state == ST_IDLE) && bus.cpu_sel_valid;
    assign bus.per_req       = per_req_q;
    assign bus.per_idx       = idx;
    assign bus.vcu_reg_rdata = mirror;
    assign bus.vcu_cur_idx   = cur_idx;
    assign bus.vcu_upd       = upd_q;
    assign bus.vcu_timeout   = timeout_q;
    assign dbg_state         = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            rr        <= '0;
            is_poll   <= 1'b0;
            gap       <= GAP_INIT;
            tcnt      <= '0;
            per_req_q <= 1'b0;
            mirror    <= '0;
            cur_idx   <= '0;
            upd_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // Clear first so a timeout set later in this block takes priority.
            if (bus.vcu_timeout_clr) begin
                timeout_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (gap != '0) begin
                        gap <= gap - GAP_W'(1);
                    end
                    if (bus.cpu_sel_valid) begin
                        idx     <= bus.cpu_sel_idx;
                        is_poll <= 1'b0;
                        if (sel_err) begin
                            mirror  <= ERR_DATA;
                            cur_idx <= bus.cpu_sel_idx;
                            upd_q   <= 1'b1;
                            state   <= ST_UPD;
                        end else begin
                            per_req_q <= 1'b1;
                            tcnt      <= '0;
                            state     <= ST_REQ;
                        end
                    end else if (bus.poll_en && (gap == '0)) begin
                        idx       <= rr;
                        is_poll   <= 1'b1;
                        per_req_q <= 1'b1;
                        tcnt      <= '0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An ack on the final allowed cycle still completes the read.
                    if (bus.per_ack) begin
                        mirror    <= bus.per_rdata;
                        cur_idx   <= idx;
                        upd_q     <= 1'b1;
                        per_req_q <= 1'b0;
                        state     <= ST_UPD;
                    end else if (tcnt == TO_LAST) begin
                        timeout_q <= 1'b1;
                        per_req_q <= 1'b0;
                        if (is_poll) begin
                            rr <= rr_next;
                        end
                        state <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                ST_UPD: begin
                    upd_q <= 1'b0;
                    if (is_poll) begin
                        rr <= rr_next;
                    end
                    gap   <= GAP_INIT;
                    state <= ST_IDLE;
                end
                default: begin
                    per_req_q <= 1'b0;
                    upd_q     <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
